pin_entry_controller: RTL and testbench

//  Sequences PIN entry for the smart lock. Consumes decoded key events from the pin pad scanner:
//  '*' opens an entry, up to 4 digits are collected, '#' closes it and compares against the stored PIN.

---
 rtl/pin_entry_controller_if.sv | 33 +++
 rtl/pin_entry_controller.sv | 191 +++++++++++++++++++
 tb/tb_pin_entry_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pin_entry_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_controller_if
// Description : Key-event and status bundle between the pin pad side and the
//               PIN entry controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pin_entry_controller_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        entry_active;
    logic [2:0]  digit_count;
    logic [15:0] pin_value;
    logic        result_valid;
    logic        result_ok;
    logic        unlock;
    logic        prog_done;
    logic        locked_out;
    logic [2:0]  fail_count;

    modport master (
        output key_valid, key_code,
        input  entry_active, digit_count, pin_value, result_valid, result_ok,
               unlock, prog_done, locked_out, fail_count
    );

    modport slave (
        input  key_valid, key_code,
        output entry_active, digit_count, pin_value, result_valid, result_ok,
               unlock, prog_done, locked_out, fail_count
    );
endinterface
`default_nettype wire

// File: rtl/pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : pin_entry_controller
// Description : Smart-lock PIN entry sequencer: collects keyed digits, checks
//               them against the stored PIN, drives unlock/lockout/reprogram.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_entry_controller #(
    parameter logic [15:0] DEFAULT_PIN    = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000
) (
    input  wire logic             clk_50,
    input  wire logic             reset,
    pin_entry_controller_if.slave bus
);

    localparam logic [2:0]  S_IDLE     = 3'd0;
    localparam logic [2:0]  S_ENTRY    = 3'd1;
    localparam logic [2:0]  S_CHECK    = 3'd2;
    localparam logic [2:0]  S_UNLOCKED = 3'd3;
    localparam logic [2:0]  S_PROGRAM  = 3'd4;
    localparam logic [2:0]  S_LOCKOUT  = 3'd5;

    localparam logic [3:0]  c_KEY_A     = 4'd10;
    localparam logic [3:0]  c_KEY_STAR  = 4'd14;
    localparam logic [3:0]  c_KEY_HASH  = 4'd15;
    localparam logic [2:0]  c_MAX_FAILS = 3'(MAX_FAILS);
    localparam logic [31:0] c_TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

    logic [2:0]  r_state,        w_state;
    logic [15:0] r_buffer,       w_buffer;
    logic [2:0]  r_count,        w_count;
    logic        r_overlong,     w_overlong;
    logic [31:0] r_timer,        w_timer;
    logic [2:0]  r_fail_count,   w_fail_count;
    logic [15:0] r_stored_pin,   w_stored_pin;
    logic        r_result_valid, w_result_valid;
    logic        r_result_ok,    w_result_ok;
    logic        r_prog_done,    w_prog_done;

    logic        w_is_digit;
    logic        w_expired;
    logic        w_match;
    logic [2:0]  w_fail_inc;

    assign w_is_digit = (bus.key_code <= 4'd9);
    assign w_expired  = (r_timer == 32'd0);
    assign w_match    = (r_count == 3'd4) && !r_overlong && (r_buffer == r_stored_pin);
    assign w_fail_inc = r_fail_count + 3'd1;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_buffer       <= 16'd0;
            r_count        <= 3'd0;
            r_overlong     <= 1'b0;
            r_timer        <= 32'd0;
            r_fail_count   <= 3'd0;
            r_stored_pin   <= DEFAULT_PIN;
            r_result_valid <= 1'b0;
            r_result_ok    <= 1'b0;
            r_prog_done    <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_buffer       <= w_buffer;
            r_count        <= w_count;
            r_overlong     <= w_overlong;
            r_timer        <= w_timer;
            r_fail_count   <= w_fail_count;
            r_stored_pin   <= w_stored_pin;
            r_result_valid <= w_result_valid;
            r_result_ok    <= w_result_ok;
            r_prog_done    <= w_prog_done;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_buffer       = r_buffer;
        w_count        = r_count;
        w_overlong     = r_overlong;
        w_timer        = w_expired ? 32'd0 : (r_timer - 32'd1);
        w_fail_count   = r_fail_count;
        w_stored_pin   = r_stored_pin;
        w_result_valid = 1'b0;
        w_result_ok    = 1'b0;
        w_prog_done    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.key_valid && (bus.key_code == c_KEY_STAR)) begin
                    w_state    = S_ENTRY;
                    w_buffer   = 16'd0;
                    w_count    = 3'd0;
                    w_overlong = 1'b0;
                    w_timer    = c_TIMEOUT_LOAD;
                end
            end

            S_ENTRY, S_PROGRAM: begin
                // Expiry is the fallback; any accepted key below overrides it.
                if (w_expired) begin
                    w_state = S_IDLE;
                end
                if (bus.key_valid) begin
                    if (w_is_digit) begin
                        w_state = r_state;
                        w_timer = c_TIMEOUT_LOAD;
                        if (r_count < 3'd4) begin
                            w_buffer = {r_buffer[11:0], bus.key_code};
                            w_count  = r_count + 3'd1;
                        end else begin
                            w_overlong = 1'b1;
                        end
                    end else if (bus.key_code == c_KEY_STAR) begin
                        w_state    = r_state;
                        w_buffer   = 16'd0;
                        w_count    = 3'd0;
                        w_overlong = 1'b0;
                        w_timer    = c_TIMEOUT_LOAD;
                    end else if (bus.key_code == c_KEY_HASH) begin
                        if (r_state == S_ENTRY) begin
                            w_state = S_CHECK;
                        end else begin
                            w_state = S_IDLE;
                            if ((r_count == 3'd4) && !r_overlong) begin
                                w_stored_pin = r_buffer;
                                w_prog_done  = 1'b1;
                            end
                        end
                    end
                end
            end

            S_CHECK: begin
                w_result_valid = 1'b1;
                if (w_match) begin
                    w_result_ok  = 1'b1;
                    w_fail_count = 3'd0;
                    w_state      = S_UNLOCKED;
                    w_timer      = c_TIMEOUT_LOAD;
                end else if (w_fail_inc >= c_MAX_FAILS) begin
                    w_fail_count = c_MAX_FAILS;
                    w_state      = S_LOCKOUT;
                    w_timer      = c_LOCKOUT_LOAD;
                end else begin
                    w_fail_count = w_fail_inc;
                    w_state      = S_IDLE;
                end
            end

            S_UNLOCKED: begin
                if (bus.key_valid && (bus.key_code == c_KEY_A)) begin
                    w_state    = S_PROGRAM;
                    w_buffer   = 16'd0;
                    w_count    = 3'd0;
                    w_overlong = 1'b0;
                    w_timer    = c_TIMEOUT_LOAD;
                end else if (w_expired) begin
                    w_state = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (w_expired) begin
                    w_state      = S_IDLE;
                    w_fail_count = 3'd0;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.entry_active = (r_state == S_ENTRY) || (r_state == S_PROGRAM);
    assign bus.digit_count  = r_count;
    assign bus.pin_value    = r_buffer;
    assign bus.result_valid = r_result_valid;
    assign bus.result_ok    = r_result_ok;
    assign bus.unlock       = (r_state == S_UNLOCKED);
    assign bus.prog_done    = r_prog_done;
    assign bus.locked_out   = (r_state == S_LOCKOUT);
    assign bus.fail_count   = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pin_entry_controller
// Description : Directed self-checking bench for pin_entry_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_entry_controller;

    localparam int c_TIMEOUT = 20;
    localparam int c_LOCKOUT = 50;

    logic clk_50;
    logic reset;
    int   n_cmp;
    int   n_err;

    pin_entry_controller_if bus ();

    pin_entry_controller #(
        .DEFAULT_PIN    (16'h1234),
        .MAX_FAILS      (3),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .LOCKOUT_CYCLES (c_LOCKOUT)
    ) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus.slave)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Sampling and driving both happen 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
    endtask

    // '*', the given digits MSD first, then '#'; returns with DUT in CHECK.
    task automatic enter_pin(input logic [23:0] digits, input int n);
        press(4'd14);
        for (int i = n - 1; i >= 0; i--) press(digits[i*4 +: 4]);
        press(4'd15);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {4'd0, bus.entry_active, bus.digit_count, bus.pin_value, bus.result_valid,
                bus.result_ok, bus.unlock, bus.prog_done, bus.locked_out, bus.fail_count};
    endfunction

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        tick(2);
        check("reset_outputs", all_outs(), 32'd0);
        reset = 1'b0;
        tick();

        // Correct PIN, result latency, unlock hold time
        press(4'd14);
        check("star_entry_active", 32'(bus.entry_active), 32'd1);
        check("star_count", 32'(bus.digit_count), 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("t1_pin_value", 32'(bus.pin_value), 32'h1234);
        check("t1_count", 32'(bus.digit_count), 32'd4);
        press(4'd15);
        check("t1_check_no_result", {30'd0, bus.result_valid, bus.entry_active}, 32'd0);
        tick();
        check("t1_result", {29'd0, bus.result_valid, bus.result_ok, bus.unlock}, 32'b111);
        tick();
        check("t1_result_pulse", 32'(bus.result_valid), 32'd0);
        tick(c_TIMEOUT - 2);
        check("t1_unlock_last", 32'(bus.unlock), 32'd1);
        tick();
        check("t1_unlock_end", 32'(bus.unlock), 32'd0);
        check("t1_idle_hold", {16'd0, bus.pin_value}, 32'h1234);

        // Three consecutive failures -> lockout
        enter_pin(24'h001235, 4);
        tick();
        check("t2_fail1", {28'd0, bus.result_valid, bus.result_ok, bus.fail_count[1:0]}, 32'b1001);
        enter_pin(24'h001235, 4);
        tick();
        check("t2_fail2", 32'(bus.fail_count), 32'd2);
        enter_pin(24'h001235, 4);
        tick();
        check("t2_fail3", {27'd0, bus.result_valid, bus.result_ok, bus.locked_out, bus.fail_count[1:0]}, 32'b10111);
        press(4'd14);
        check("t2_star_ignored", {30'd0, bus.locked_out, bus.entry_active}, 32'b10);
        tick(c_LOCKOUT - 2);
        check("t2_lock_last", 32'(bus.locked_out), 32'd1);
        tick();
        check("t2_lock_end", {28'd0, bus.locked_out, bus.fail_count}, 32'd0);

        // Short entry, overlong entry, restart
        enter_pin(24'h000123, 3);
        tick();
        check("t3_short", {28'd0, bus.result_ok, bus.fail_count}, 32'd1);
        press(4'd14); press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("t3_overlong_buf", {13'd0, bus.digit_count, bus.pin_value}, {13'd0, 3'd4, 16'h1234});
        press(4'd15);
        tick();
        check("t3_overlong", {27'd0, bus.result_valid, bus.result_ok, bus.fail_count}, {27'd0, 1'b1, 1'b0, 3'd2});
        press(4'd14); press(4'd9); press(4'd14);
        check("t3_restart", {13'd0, bus.digit_count, bus.pin_value}, 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd15);
        tick();
        check("t3_pass", {27'd0, bus.result_ok, bus.unlock, bus.fail_count}, {27'd0, 1'b1, 1'b1, 3'd0});

        // Reprogram the PIN while unlocked
        press(4'd10);
        check("t4_program", {30'd0, bus.entry_active, bus.unlock}, 32'b10);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd15);
        check("t4_prog_done", {30'd0, bus.prog_done, bus.entry_active}, 32'b10);
        tick();
        check("t4_prog_pulse", 32'(bus.prog_done), 32'd0);
        enter_pin(24'h001234, 4);
        tick();
        check("t4_old_pin", {28'd0, bus.result_ok, bus.fail_count}, 32'd1);
        enter_pin(24'h009876, 4);
        tick();
        check("t4_new_pin", {27'd0, bus.result_ok, bus.unlock, bus.fail_count}, {27'd0, 1'b1, 1'b1, 3'd0});
        tick(c_TIMEOUT);
        check("t4_unlock_end", 32'(bus.unlock), 32'd0);

        // Entry timeout and key-in-expiry-cycle
        enter_pin(24'h000001, 1);
        tick();
        check("t5_pre_fail", 32'(bus.fail_count), 32'd1);
        press(4'd14); press(4'd1); press(4'd2);
        tick(c_TIMEOUT - 1);
        check("t5_before_expiry", 32'(bus.entry_active), 32'd1);
        tick();
        check("t5_expired", {25'd0, bus.entry_active, bus.digit_count, bus.fail_count}, {25'd0, 1'b0, 3'd2, 3'd1});
        press(4'd14);
        tick(c_TIMEOUT - 1);
        press(4'd5);
        check("t5_key_wins", {28'd0, bus.entry_active, bus.digit_count}, {28'd0, 1'b1, 3'd1});
        tick(c_TIMEOUT - 1);
        check("t5_reload_hold", 32'(bus.entry_active), 32'd1);
        tick();
        check("t5_reload_expiry", 32'(bus.entry_active), 32'd0);

        // Reset mid-ENTRY and mid-PROGRAM restores the default PIN
        press(4'd14); press(4'd1);
        reset = 1'b1;
        tick();
        check("t6_reset_entry", all_outs(), 32'd0);
        reset = 1'b0;
        enter_pin(24'h001234, 4);
        tick();
        check("t6_default_pin", {30'd0, bus.result_ok, bus.unlock}, 32'b11);
        press(4'd10); press(4'd5); press(4'd5);
        check("t6_prog_digits", 32'(bus.digit_count), 32'd2);
        reset = 1'b1;
        tick();
        check("t6_reset_program", all_outs(), 32'd0);
        reset = 1'b0;
        enter_pin(24'h001234, 4);
        tick();
        check("t6_pin_after_reset", {30'd0, bus.result_ok, bus.unlock}, 32'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
